// File: rtl/alu_seq_ctrl_pkg.sv
// Shared op-code, FSM state and counter-width definitions for the ALU sequencing stage.
package alu_seq_defs;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_NOR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EVAL = 2'd1;
    localparam logic [1:0] ST_MUL  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int unsigned DEF_WIDTH = 32;

    // Wide enough to hold the iteration count itself, not just WIDTH-1.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w) + 1;
    endfunction

    localparam int unsigned CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/alu_seq_ctrl_mul.sv
// Iterative shift-add multiplier, one multiplier bit per step, LSB first.
// Present only when ALU_SEQ_MUL_EN is defined.
`ifdef ALU_SEQ_MUL_EN
module shift_add_mul
    import alu_seq_defs::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] product,
    output logic             last
);

    localparam int unsigned CW = cnt_width(WIDTH);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
            cnt     <= '0;
        end else if (load) begin
            mcand   <= a;
            mplier  <= b;
            product <= '0;
            cnt     <= '0;
        end else if (step) begin
            if (mplier[0])
                product <= product + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
        end
    end

    // No early exit on a zero multiplier: latency stays fixed at WIDTH steps.
    assign last = (cnt == CW'(WIDTH - 1));

endmodule
`endif

// File: rtl/alu_seq_ctrl.sv
// Start/busy sequencer feeding the mux8to1 result-select bank; captures bank output F.
// Optional shift-add multiplier on mux input D7 enabled by ALU_SEQ_MUL_EN.
module alu_seq_ctrl
    import alu_seq_defs::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] opa,
    output logic [WIDTH-1:0] opb,
    output logic [2:0]       sel,
    output logic [WIDTH-1:0] mul_p,
    input  logic [WIDTH-1:0] mux_f,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
);

    logic [1:0] state;
    logic       armed;
    logic       accept;

    // armed stays low for the first edge after reset release, so a start
    // coinciding with release is not taken.
    assign accept = start && armed && (state == ST_IDLE);

`ifdef ALU_SEQ_MUL_EN
    logic mul_last;

    shift_add_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .load    (accept),
        .step    (state == ST_MUL),
        .a       (a_in),
        .b       (b_in),
        .product (mul_p),
        .last    (mul_last)
    );
`else
    assign mul_p = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            armed  <= 1'b0;
            opa    <= '0;
            opb    <= '0;
            sel    <= '0;
            result <= '0;
        end else begin
            armed <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        opa <= a_in;
                        opb <= b_in;
                        sel <= op;
`ifdef ALU_SEQ_MUL_EN
                        state <= (op == OP_MUL) ? ST_MUL : ST_EVAL;
`else
                        state <= ST_EVAL;
`endif
                    end
                end
`ifdef ALU_SEQ_MUL_EN
                ST_MUL: begin
                    if (mul_last)
                        state <= ST_EVAL;
                end
`endif
                ST_EVAL: begin
                    result <= mux_f;
                    state  <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_EVAL) || (state == ST_MUL);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Randomized self-checking bench for alu_seq_ctrl; models the mux8to1 bank on mux_f.
// Expectations follow ALU_SEQ_MUL_EN the same way the design does.
module tb_alu_seq_ctrl;

    localparam int W = 32;

`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a_in, b_in;
    logic [W-1:0] opa, opb, mul_p, mux_f, result;
    logic [2:0]   sel;
    logic         busy, done;

    int ntotal = 0;
    int nbad   = 0;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a_in   (a_in),
        .b_in   (b_in),
        .opa    (opa),
        .opb    (opb),
        .sel    (sel),
        .mul_p  (mul_p),
        .mux_f  (mux_f),
        .result (result),
        .busy   (busy),
        .done   (done)
    );

    // Downstream mux bank with its functional units; {S0,S1,S2} = sel picks D0..D7.
    always_comb begin
        case (sel)
            3'd0:    mux_f = opa & opb;
            3'd1:    mux_f = opa | opb;
            3'd2:    mux_f = opa + opb;
            3'd3:    mux_f = opa ^ opb;
            3'd4:    mux_f = opa - opb;
            3'd5:    mux_f = (opa < opb) ? 32'd1 : 32'd0;
            3'd6:    mux_f = ~(opa | opb);
            default: mux_f = mul_p;
        endcase
    end

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        ntotal++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_f(input logic [2:0] o, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        case (o)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a + b;
            3'd3:    return a ^ b;
            3'd4:    return a - b;
            3'd5:    return (a < b) ? 32'd1 : 32'd0;
            3'd6:    return ~(a | b);
            default: return MUL_ON ? (a * b) : '0;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit hammer);
        logic [W-1:0] exp;
        int exp_lat, lat, bcnt;
        bit unstable;
        exp     = ref_f(o, a, b);
        exp_lat = (o == 3'b111 && MUL_ON) ? W + 2 : 2;
        @(negedge clk);
        start = 1'b1; op = o; a_in = a; b_in = b;
        @(negedge clk);
        lat = 1; bcnt = 0; unstable = 1'b0;
        while (!done && lat < 200) begin
            if (busy) bcnt++;
            if (opa !== a || opb !== b || sel !== o) unstable = 1'b1;
            start = hammer; op = 3'($urandom); a_in = $urandom; b_in = $urandom;
            @(negedge clk);
            lat++;
        end
        chk("latency", W'(lat), W'(exp_lat));
        chk("busy_cycles", W'(bcnt), W'(exp_lat - 1));
        chk("result", result, exp);
        chk("mul_p", mul_p, (o == 3'b111) ? exp : '0);
        chk("busy_at_done", W'(busy), '0);
        chk("ops_held", W'(unstable), '0);
        chk("sel_at_done", W'(sel), W'(o));
        start = 1'b0;
        @(negedge clk);
        chk("done_one_pulse", W'(done), '0);
        chk("idle_not_busy", W'(busy), '0);
    endtask

    initial begin
        int dcnt;
        reset = 1'b1; start = 1'b1; op = 3'b010; a_in = 32'd5; b_in = 32'd7;
        #12;
        chk("rst_opa", opa, '0);
        chk("rst_opb", opb, '0);
        chk("rst_sel", W'(sel), '0);
        chk("rst_mul_p", mul_p, '0);
        chk("rst_result", result, '0);
        chk("rst_busy", W'(busy), '0);
        chk("rst_done", W'(done), '0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("release_start_ignored", W'(busy), '0);
        chk("release_opa", opa, '0);
        start = 1'b0;

        run_op(3'b010, 32'd5, 32'd7, 1'b0);
        run_op(3'b111, 32'h0000FFFF, 32'h00010001, 1'b1);

        // Abort mid-operation: MUL at iteration 10, or mid-EVAL without the multiplier.
        @(negedge clk);
        start = 1'b1; op = MUL_ON ? 3'b111 : 3'b010; a_in = $urandom; b_in = $urandom;
        @(negedge clk);
        start = 1'b0;
        repeat (MUL_ON ? 10 : 0) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_busy", W'(busy), '0);
        chk("abort_done", W'(done), '0);
        chk("abort_result", result, '0);
        chk("abort_mul_p", mul_p, '0);
        @(negedge clk);
        reset = 1'b0;
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("abort_no_done", W'(dcnt), '0);
        run_op(3'b000, 32'hF0, 32'h3C, 1'b0);

        run_op(3'b111, $urandom, 32'd0, 1'b0);
        run_op(3'b100, 32'd0, 32'd1, 1'b0);
        run_op(3'b101, 32'hFFFF_FFFF, 32'd1, 1'b0);

        for (int i = 0; i < 24; i++)
            run_op(3'($urandom), $urandom, $urandom, 1'($urandom));

        $display("test done: total=%0d bad=%0d", ntotal, nbad);
        $finish;
    end

endmodule
